// File: rtl/nap_pkg.sv
// nap_pkg: shared definitions for the nap countdown timer.
//   - key codes for the '*' and '#' keys
//   - FSM state encoding (also driven out on state_o for debug/LEDs)
//   - BCD helpers used by the mm:ss counter
// Optional feature macro used by this design: NAP_SNOOZE_EN (see nap_countdown.sv).
package nap_pkg;

    localparam logic [3:0] KEY_STAR  = 4'hA;
    localparam logic [3:0] KEY_SHARP = 4'hB;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        RUN     = 3'd2,
        PAUSE   = 3'd3,
        EXPIRED = 3'd4
    } nap_state_t;

    // Decrement a two-digit BCD value. The ones digit borrows from the tens
    // digit (x0 -> (x-1)9). Callers never pass 00.
    function automatic logic [7:0] bcd_dec8(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'h0) begin
            r = {v[7:4] - 4'h1, 4'h9};
        end else begin
            r = {v[7:4], v[3:0] - 4'h1};
        end
        return r;
    endfunction

    // Convert 0-99 to two BCD digits (used on parameters at elaboration).
    function automatic logic [7:0] bin_to_bcd8(input int unsigned v);
        return {4'((v / 32'd10) % 32'd10), 4'(v % 32'd10)};
    endfunction

endpackage

// File: rtl/nap_tick_gen.sv
// nap_tick_gen: 1 s prescaler for the nap countdown timer.
//   Counts 0..CLK_HZ-1 while enabled; the wrap cycle raises tick.
// Ports:
//   clk   in  1  system clock
//   rst   in  1  synchronous active-high reset, clears the count
//   clr   in  1  clear the count (priority over en)
//   en    in  1  count enable; count holds when low
//   tick  out 1  high on the cycle the count wraps (combinational from count)
module nap_tick_gen #(
    parameter int CLK_HZ = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] TC = CW'(CLK_HZ - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == TC);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == TC) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/nap_countdown.sv
// nap_countdown: keypad-programmed nap countdown timer (mm:ss in BCD).
//   Enter 00-99 minutes, confirm with '#', count down once per second,
//   raise alarm_start at 00:00 until alarm_stop acknowledges it.
//   Optional snooze on '*' while expired: build with NAP_SNOOZE_EN defined.
// Interface semantics: key_valid is a one-cycle strobe with no back-pressure;
//   key_code is sampled only in the cycle key_valid is high and the effect
//   is visible on the registered outputs the following cycle.
// Ports:
//   clk          in  1  system clock
//   rst          in  1  synchronous active-high reset
//   key_valid    in  1  key strobe
//   key_code     in  4  0-9 digit, 4'hA='*', 4'hB='#', others ignored
//   alarm_stop   in  1  acknowledges the alarm (only meaningful in EXPIRED)
//   alarm_start  out 1  high while EXPIRED
//   min_bcd      out 8  minutes, two BCD digits
//   sec_bcd      out 8  seconds, two BCD digits
//   running      out 1  high in RUN only
//   state_o      out 3  current FSM state code
module nap_countdown #(
    parameter int CLK_HZ     = 500000,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       alarm_stop,
    output logic       alarm_start,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic [2:0] state_o
);

    import nap_pkg::*;

    if (SNOOZE_MIN < 1 || SNOOZE_MIN > 99) begin : g_bad_snooze
        $error("nap_countdown: SNOOZE_MIN must be 1-99");
    end
    if (CLK_HZ < 2) begin : g_bad_clk_hz
        $error("nap_countdown: CLK_HZ must be at least 2");
    end

`ifdef NAP_SNOOZE_EN
    localparam logic [7:0] SNOOZE_BCD = bin_to_bcd8(SNOOZE_MIN);
`endif

    nap_state_t state, state_n;
    logic [7:0] min_n, sec_n;
    logic       pre_clr;
    logic       tick;
    logic       is_digit, is_star, is_sharp;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_star  = key_valid && (key_code == KEY_STAR);
    assign is_sharp = key_valid && (key_code == KEY_SHARP);

    nap_tick_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr),
        .en   (state == RUN),
        .tick (tick)
    );

    always_comb begin
        state_n = state;
        min_n   = min_bcd;
        sec_n   = sec_bcd;
        pre_clr = 1'b0;
        case (state)
            IDLE: begin
                if (is_digit) begin
                    state_n = ENTRY;
                    min_n   = {4'h0, key_code};
                    sec_n   = 8'h00;
                end
            end
            ENTRY: begin
                if (is_digit) begin
                    // Shift in the new digit; the oldest digit falls off.
                    min_n = {min_bcd[3:0], key_code};
                end else if (is_star) begin
                    state_n = IDLE;
                    min_n   = 8'h00;
                    sec_n   = 8'h00;
                end else if (is_sharp && (min_bcd != 8'h00)) begin
                    state_n = RUN;
                    pre_clr = 1'b1;
                end
            end
            RUN: begin
                // Any key strobe takes the cycle; a coincident tick is lost.
                if (key_valid) begin
                    if (is_sharp) begin
                        state_n = PAUSE;
                    end else if (is_star) begin
                        state_n = IDLE;
                        min_n   = 8'h00;
                        sec_n   = 8'h00;
                    end
                end else if (tick) begin
                    if (sec_bcd != 8'h00) begin
                        sec_n = bcd_dec8(sec_bcd);
                    end else begin
                        sec_n = 8'h59;
                        min_n = bcd_dec8(min_bcd);
                    end
                    if ((min_n == 8'h00) && (sec_n == 8'h00)) begin
                        state_n = EXPIRED;
                    end
                end
            end
            PAUSE: begin
                // Prescaler is not cleared here, so it resumes mid-second.
                if (is_sharp) begin
                    state_n = RUN;
                end else if (is_star) begin
                    state_n = IDLE;
                    min_n   = 8'h00;
                    sec_n   = 8'h00;
                end
            end
            EXPIRED: begin
                if (alarm_stop) begin
                    state_n = IDLE;
                    min_n   = 8'h00;
                    sec_n   = 8'h00;
                end
`ifdef NAP_SNOOZE_EN
                else if (is_star) begin
                    state_n = RUN;
                    min_n   = SNOOZE_BCD;
                    sec_n   = 8'h00;
                    pre_clr = 1'b1;
                end
`endif
            end
            default: begin
                state_n = IDLE;
                min_n   = 8'h00;
                sec_n   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            min_bcd     <= 8'h00;
            sec_bcd     <= 8'h00;
            alarm_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            state       <= state_n;
            min_bcd     <= min_n;
            sec_bcd     <= sec_n;
            alarm_start <= (state_n == EXPIRED);
            running     <= (state_n == RUN);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_nap_countdown.sv
// tb_nap_countdown: directed bench for nap_countdown with CLK_HZ=4.
// Expected output vectors {state, alarm_start, running, min, sec} are queued
// when stimulus is applied and popped/compared once the DUT has responded.
module tb_nap_countdown;

    localparam int CLK_HZ = 4;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       alarm_stop;
    logic       alarm_start;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic [2:0] state_o;

    int errors = 0;
    int checks = 0;

    logic [20:0] exp_q[$];
    string       tag_q[$];

    nap_countdown #(
        .CLK_HZ     (CLK_HZ),
        .SNOOZE_MIN (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .alarm_stop  (alarm_stop),
        .alarm_start (alarm_start),
        .min_bcd     (min_bcd),
        .sec_bcd     (sec_bcd),
        .running     (running),
        .state_o     (state_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n cycles; inputs change and outputs are sampled 1 time unit after posedge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_push(input string tag, input logic [2:0] st, input logic al,
                            input logic run, input logic [7:0] mn, input logic [7:0] sc);
        exp_q.push_back({st, al, run, mn, sc});
        tag_q.push_back(tag);
    endtask

    task automatic exp_pop();
        logic [20:0] e;
        logic [20:0] o;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = {state_o, alarm_start, running, min_bcd, sec_bcd};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed st=%0d al=%b run=%b %h:%h expected st=%0d al=%b run=%b %h:%h",
                   t, o[20:18], o[17], o[16], o[15:8], o[7:0],
                   e[20:18], e[17], e[16], e[15:8], e[7:0]);
        end
    endtask

    // Driver: one key strobe, then compare the response.
    task automatic key_exp(input logic [3:0] k, input string tag, input logic [2:0] st,
                           input logic al, input logic run, input logic [7:0] mn,
                           input logic [7:0] sc);
        exp_push(tag, st, al, run, mn, sc);
        key_valid = 1'b1;
        key_code  = k;
        step(1);
        key_valid = 1'b0;
        key_code  = 4'h0;
        exp_pop();
    endtask

    task automatic wait_exp(input int n, input string tag, input logic [2:0] st,
                            input logic al, input logic run, input logic [7:0] mn,
                            input logic [7:0] sc);
        exp_push(tag, st, al, run, mn, sc);
        step(n);
        exp_pop();
    endtask

    initial begin
        rst        = 1'b1;
        key_valid  = 1'b0;
        key_code   = 4'h0;
        alarm_stop = 1'b0;
        step(1);
        wait_exp(1, "reset_hold", 3'd0, 0, 0, 8'h00, 8'h00);
        rst = 1'b0;
        wait_exp(1, "reset_release", 3'd0, 0, 0, 8'h00, 8'h00);

        // 1: 25 minutes, first tick after CLK_HZ cycles
        key_exp(4'd2,  "t1_digit2", 3'd1, 0, 0, 8'h02, 8'h00);
        key_exp(4'd5,  "t1_digit5", 3'd1, 0, 0, 8'h25, 8'h00);
        key_exp(4'hB,  "t1_start",  3'd2, 0, 1, 8'h25, 8'h00);
        wait_exp(3, "t1_pre_tick", 3'd2, 0, 1, 8'h25, 8'h00);
        wait_exp(1, "t1_tick1",    3'd2, 0, 1, 8'h24, 8'h59);
        wait_exp(4, "t1_tick2",    3'd2, 0, 1, 8'h24, 8'h58);
        key_exp(4'hA,  "t1_cancel", 3'd0, 0, 0, 8'h00, 8'h00);

        // 3: entry shifting, '#' on 00, '*' cancel, keys ignored in IDLE
        key_exp(4'd1,  "t3_d1",        3'd1, 0, 0, 8'h01, 8'h00);
        key_exp(4'd2,  "t3_d2",        3'd1, 0, 0, 8'h12, 8'h00);
        key_exp(4'd3,  "t3_d3_drop",   3'd1, 0, 0, 8'h23, 8'h00);
        key_exp(4'hA,  "t3_star",      3'd0, 0, 0, 8'h00, 8'h00);
        key_exp(4'hB,  "t3_idle_hash", 3'd0, 0, 0, 8'h00, 8'h00);
        key_exp(4'hA,  "t3_idle_star", 3'd0, 0, 0, 8'h00, 8'h00);
        key_exp(4'd0,  "t3_z1",        3'd1, 0, 0, 8'h00, 8'h00);
        key_exp(4'd0,  "t3_z2",        3'd1, 0, 0, 8'h00, 8'h00);
        key_exp(4'hB,  "t3_hash_zero", 3'd1, 0, 0, 8'h00, 8'h00);
        key_exp(4'hA,  "t3_clear",     3'd0, 0, 0, 8'h00, 8'h00);

        // 2: 01:00 runs out after 60 ticks, alarm_stop wins over a key
        key_exp(4'd0,  "t2_d0",    3'd1, 0, 0, 8'h00, 8'h00);
        key_exp(4'd1,  "t2_d1",    3'd1, 0, 0, 8'h01, 8'h00);
        key_exp(4'hB,  "t2_start", 3'd2, 0, 1, 8'h01, 8'h00);
        wait_exp(50,  "t2_mid",     3'd2, 0, 1, 8'h00, 8'h48);
        wait_exp(189, "t2_last",    3'd2, 0, 1, 8'h00, 8'h01);
        wait_exp(1,   "t2_expired", 3'd4, 1, 0, 8'h00, 8'h00);
        key_exp(4'd7,  "t2_digit_ign", 3'd4, 1, 0, 8'h00, 8'h00);
        key_exp(4'hB,  "t2_hash_ign",  3'd4, 1, 0, 8'h00, 8'h00);
        exp_push("t2_stop", 3'd0, 0, 0, 8'h00, 8'h00);
        alarm_stop = 1'b1;
        key_valid  = 1'b1;
        key_code   = 4'hA;
        step(1);
        alarm_stop = 1'b0;
        key_valid  = 1'b0;
        key_code   = 4'h0;
        exp_pop();

        // 4: pause freezes time and prescaler, resume keeps the partial second
        key_exp(4'd1,  "t4_d1",    3'd1, 0, 0, 8'h01, 8'h00);
        key_exp(4'd0,  "t4_d0",    3'd1, 0, 0, 8'h10, 8'h00);
        key_exp(4'hB,  "t4_start", 3'd2, 0, 1, 8'h10, 8'h00);
        wait_exp(5, "t4_borrow", 3'd2, 0, 1, 8'h09, 8'h59);
        key_exp(4'hB,  "t4_pause", 3'd3, 0, 0, 8'h09, 8'h59);
        exp_push("t4_stop_ign", 3'd3, 0, 0, 8'h09, 8'h59);
        alarm_stop = 1'b1;
        step(1);
        alarm_stop = 1'b0;
        exp_pop();
        wait_exp(19, "t4_hold", 3'd3, 0, 0, 8'h09, 8'h59);
        key_exp(4'hB,  "t4_resume", 3'd2, 0, 1, 8'h09, 8'h59);
        wait_exp(1, "t4_partial", 3'd2, 0, 1, 8'h09, 8'h59);
        wait_exp(1, "t4_tick",    3'd2, 0, 1, 8'h09, 8'h58);

        // 5: key coincident with tick drops the tick; reset mid-run
        wait_exp(3, "t5_before", 3'd2, 0, 1, 8'h09, 8'h58);
        key_exp(4'hB,  "t5_key_tick", 3'd3, 0, 0, 8'h09, 8'h58);
        key_exp(4'hB,  "t5_resume",   3'd2, 0, 1, 8'h09, 8'h58);
        wait_exp(2, "t5_no_tick", 3'd2, 0, 1, 8'h09, 8'h58);
        exp_push("t5_reset", 3'd0, 0, 0, 8'h00, 8'h00);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        exp_pop();
        wait_exp(1, "t5_after_rst", 3'd0, 0, 0, 8'h00, 8'h00);

        // 6: '*' while expired
        key_exp(4'd0,  "t6_d0",    3'd1, 0, 0, 8'h00, 8'h00);
        key_exp(4'd1,  "t6_d1",    3'd1, 0, 0, 8'h01, 8'h00);
        key_exp(4'hB,  "t6_start", 3'd2, 0, 1, 8'h01, 8'h00);
        wait_exp(240, "t6_expired", 3'd4, 1, 0, 8'h00, 8'h00);
`ifdef NAP_SNOOZE_EN
        key_exp(4'hA,  "t6_snooze", 3'd2, 0, 1, 8'h05, 8'h00);
        wait_exp(4, "t6_snooze_tick", 3'd2, 0, 1, 8'h04, 8'h59);
        key_exp(4'hA,  "t6_cancel", 3'd0, 0, 0, 8'h00, 8'h00);
`else
        key_exp(4'hA,  "t6_star_ign", 3'd4, 1, 0, 8'h00, 8'h00);
        wait_exp(3, "t6_still_exp", 3'd4, 1, 0, 8'h00, 8'h00);
        exp_push("t6_stop", 3'd0, 0, 0, 8'h00, 8'h00);
        alarm_stop = 1'b1;
        step(1);
        alarm_stop = 1'b0;
        exp_pop();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
